// File: rtl/encoder_pkg.sv
// Shared types and constants for the RGB-to-YUV frame encoder: FSM state set,
// fixed-point (Q16) colour-space coefficients and the offset/rounding terms.
package encoder_pkg;

    typedef enum logic [3:0] {
        StIdle, StRdA, StRdB, StRdC, StCapB, StCapC,
        StCscE, StCscO, StWrY, StWrU, StWrV, StDone
    } state_e;

    localparam int signed CoefYR = 16843;
    localparam int signed CoefYG = 33030;
    localparam int signed CoefYB = 6423;
    localparam int signed CoefUR = -9699;
    localparam int signed CoefUG = -19071;
    localparam int signed CoefUB = 28770;
    localparam int signed CoefVR = 28770;
    localparam int signed CoefVG = -24117;
    localparam int signed CoefVB = -4653;

    localparam int signed YOffset  = 1048576;  // 16 << 16
    localparam int signed UvOffset = 8388608;  // 128 << 16
    localparam int signed Rounding = 32768;    // 0.5 in Q16

    function automatic logic [7:0] clip8(input int signed v);
        if (v < 0) begin
            return 8'd0;
        end else if (v > 255) begin
            return 8'd255;
        end
        return v[7:0];
    endfunction

endpackage

// File: rtl/rgb_yuv_encoder_if.sv
// Control and SRAM bus of the RGB-to-YUV encoder; master is the encoder side,
// slave is the memory/controller side.
interface rgb_yuv_encoder_if;
    logic        Enable;
    logic        Done;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    modport master (
        input  Enable, SRAM_read_data,
        output Done, SRAM_address, SRAM_write_data, SRAM_we_n
    );

    modport slave (
        output Enable, SRAM_read_data,
        input  Done, SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/rgb_to_yuv_csc.sv
// Combinational 8-bit RGB to clipped 8-bit YUV converter in Q16 fixed point;
// the encoder time-shares a single instance between the even and odd pixel.
module rgb_to_yuv_csc
    import encoder_pkg::*;
(
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [7:0] y,
    output logic [7:0] u,
    output logic [7:0] v
);

    int signed rs, gs, bs;

    always_comb begin
        rs = int'(r);
        gs = int'(g);
        bs = int'(b);
        y  = clip8((CoefYR * rs + CoefYG * gs + CoefYB * bs + YOffset + Rounding) >>> 16);
        u  = clip8((CoefUR * rs + CoefUG * gs + CoefUB * bs + UvOffset + Rounding) >>> 16);
        v  = clip8((CoefVR * rs + CoefVG * gs + CoefVB * bs + UvOffset + Rounding) >>> 16);
    end

endmodule

// File: rtl/rgb_yuv_encoder.sv
// Frame encoder: reads packed RGB pixel pairs from SRAM, writes Y per pair and
// U/V per 4 pixels. Define UV_AVERAGE_EN to average even/odd chroma per pair.
module rgb_yuv_encoder
    import encoder_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = 320,
    parameter int unsigned IMAGE_HEIGHT = 240,
    parameter logic [17:0] Y_BASE       = 18'd0,
    parameter logic [17:0] U_BASE       = 18'd38400,
    parameter logic [17:0] V_BASE       = 18'd57600,
    parameter logic [17:0] RGB_BASE     = 18'd146944
) (
    input logic               Clock,
    input logic               Reset,
    rgb_yuv_encoder_if.master bus
);

    localparam logic [17:0] UvLast = 18'(IMAGE_WIDTH * IMAGE_HEIGHT / 4 - 1);

    state_e      state;
    logic        odd_pair;
    logic [17:0] rgb_cnt, y_cnt, uv_cnt;
    logic [15:0] w0, w1, w2;
    logic [7:0]  y_e, u_e, v_e, u_p0, u_p1, v_p0, v_p1;
    logic [7:0]  csc_r, csc_g, csc_b, csc_y, csc_u, csc_v, u_pair, v_pair;

    // Words are {R0,G0}, {B0,R1}, {G1,B1}; the odd pixel is converted in CSC_O.
    always_comb begin
        if (state == StCscO) begin
            {csc_r, csc_g, csc_b} = {w1[7:0], w2};
        end else begin
            {csc_r, csc_g, csc_b} = {w0, w1[15:8]};
        end
    end

    rgb_to_yuv_csc u_csc (
        .r (csc_r),
        .g (csc_g),
        .b (csc_b),
        .y (csc_y),
        .u (csc_u),
        .v (csc_v)
    );

`ifdef UV_AVERAGE_EN
    logic [8:0] u_sum, v_sum;
    always_comb begin
        u_sum  = {1'b0, u_e} + {1'b0, csc_u} + 9'd1;
        v_sum  = {1'b0, v_e} + {1'b0, csc_v} + 9'd1;
        u_pair = 8'(u_sum >> 1);
        v_pair = 8'(v_sum >> 1);
    end
`else
    always_comb begin
        u_pair = u_e;
        v_pair = v_e;
    end
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state               <= StIdle;
            odd_pair            <= 1'b0;
            rgb_cnt             <= '0;
            y_cnt               <= '0;
            uv_cnt              <= '0;
            {w0, w1, w2}        <= '0;
            {y_e, u_e, v_e}     <= '0;
            {u_p0, u_p1}        <= '0;
            {v_p0, v_p1}        <= '0;
            bus.Done            <= 1'b0;
            bus.SRAM_address    <= '0;
            bus.SRAM_write_data <= '0;
            bus.SRAM_we_n       <= 1'b1;
        end else begin
            case (state)
                StIdle: begin
                    if (bus.Enable) begin
                        state            <= StRdA;
                        bus.SRAM_address <= RGB_BASE + rgb_cnt;
                        rgb_cnt          <= rgb_cnt + 18'd1;
                    end
                end
                StRdA: begin
                    state            <= StRdB;
                    bus.SRAM_address <= RGB_BASE + rgb_cnt;
                    rgb_cnt          <= rgb_cnt + 18'd1;
                end
                StRdB: begin
                    state            <= StRdC;
                    bus.SRAM_address <= RGB_BASE + rgb_cnt;
                    rgb_cnt          <= rgb_cnt + 18'd1;
                end
                StRdC: begin
                    w0    <= bus.SRAM_read_data;
                    state <= StCapB;
                end
                StCapB: begin
                    w1    <= bus.SRAM_read_data;
                    state <= StCapC;
                end
                StCapC: begin
                    w2    <= bus.SRAM_read_data;
                    state <= StCscE;
                end
                StCscE: begin
                    {y_e, u_e, v_e} <= {csc_y, csc_u, csc_v};
                    state           <= StCscO;
                end
                StCscO: begin
                    if (odd_pair) begin
                        u_p1 <= u_pair;
                        v_p1 <= v_pair;
                    end else begin
                        u_p0 <= u_pair;
                        v_p0 <= v_pair;
                    end
                    bus.SRAM_address    <= Y_BASE + y_cnt;
                    bus.SRAM_write_data <= {y_e, csc_y};
                    bus.SRAM_we_n       <= 1'b0;
                    y_cnt               <= y_cnt + 18'd1;
                    state               <= StWrY;
                end
                StWrY: begin
                    odd_pair <= ~odd_pair;
                    if (odd_pair) begin
                        bus.SRAM_address    <= U_BASE + uv_cnt;
                        bus.SRAM_write_data <= {u_p0, u_p1};
                        bus.SRAM_we_n       <= 1'b0;
                        state               <= StWrU;
                    end else begin
                        bus.SRAM_address <= RGB_BASE + rgb_cnt;
                        bus.SRAM_we_n    <= 1'b1;
                        rgb_cnt          <= rgb_cnt + 18'd1;
                        state            <= StRdA;
                    end
                end
                StWrU: begin
                    bus.SRAM_address    <= V_BASE + uv_cnt;
                    bus.SRAM_write_data <= {v_p0, v_p1};
                    state               <= StWrV;
                end
                StWrV: begin
                    bus.SRAM_we_n <= 1'b1;
                    uv_cnt        <= uv_cnt + 18'd1;
                    if (uv_cnt == UvLast) begin
                        bus.Done <= 1'b1;
                        state    <= StDone;
                    end else begin
                        bus.SRAM_address <= RGB_BASE + rgb_cnt;
                        rgb_cnt          <= rgb_cnt + 18'd1;
                        state            <= StRdA;
                    end
                end
                StDone: begin
                    bus.Done      <= 1'b0;
                    bus.SRAM_we_n <= 1'b1;
                    rgb_cnt       <= '0;
                    y_cnt         <= '0;
                    uv_cnt        <= '0;
                    odd_pair      <= 1'b0;
                    state         <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
